// File: rtl/lab2_proc_multi_drop_unit.sv
// Drop unit: discards memory responses owed to squashed instructions, in arrival order.
// The pass path from istream to ostream is purely combinational; only the owed count is stored.
module lab2_proc_multi_drop_unit #(
  parameter int unsigned p_msg_nbits   = 32,
  parameter int unsigned p_max_pending = 4,
  localparam int unsigned c_cnt_nbits  = $clog2(p_max_pending + 1)
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   drop,
  output logic                   drop_rdy,

  input  logic [p_msg_nbits-1:0] istream_msg,
  input  logic                   istream_val,
  output logic                   istream_rdy,

  output logic [p_msg_nbits-1:0] ostream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,

  output logic [c_cnt_nbits-1:0] pending,
  output logic                   idle,
  output logic                   drop_err
);

  localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_max_pending);

  typedef enum logic [1:0] {
    ModePass,
    ModeSameDrop,
    ModeArm,
    ModeDrain
  } mode_e;

  logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic  cnt_zero;
  logic  cnt_full;
  logic  drop_go;
  logic  in_go;
  logic  cnt_inc;
  logic  cnt_dec;
  mode_e mode;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_full = (cnt_q == c_max);

  // A message arriving this cycle frees a slot, so a full unit may still accept a drop.
  assign drop_rdy = !cnt_full || istream_val;
  assign drop_go  = drop && drop_rdy;
  assign in_go    = istream_val && istream_rdy;

  always_comb begin
    mode = ModePass;
    if (!cnt_zero) begin
      mode = ModeDrain;
    end else if (drop_go) begin
      mode = istream_val ? ModeSameDrop : ModeArm;
    end
  end

  always_comb begin
    ostream_val = 1'b0;
    istream_rdy = 1'b1;
    unique case (mode)
      ModePass: begin
        ostream_val = istream_val;
        istream_rdy = ostream_rdy;
      end
      ModeSameDrop, ModeArm, ModeDrain: begin
        ostream_val = 1'b0;
        istream_rdy = 1'b1;
      end
      default: begin
        ostream_val = 1'b0;
        istream_rdy = 1'b1;
      end
    endcase
  end

  assign ostream_msg = istream_msg;

  // A drop that meets its own message in the same cycle never touches the counter.
  assign cnt_inc = drop_go && !(cnt_zero && istream_val);
  assign cnt_dec = !cnt_zero && in_go;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q || (drop && !drop_rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign pending  = cnt_q;
  assign idle     = cnt_zero;
  assign drop_err = err_q;

endmodule
